// File: rtl/checkpoint_ctrl_pkg.sv
// Shared definitions for the rename-stage branch checkpoint controller.
// Latency: n/a (types, constants and a slot-distance helper only).
// Backpressure: n/a.
package checkpoint_ctrl_pkg;

   localparam int RENAME_WIDTH  = 3;                       // lanes per rename group
   localparam int CP_NUM        = 4;                       // checkpoint slots
   localparam int CP_INDEX_SIZE = 2;                       // log2(CP_NUM)
   localparam int CNT_W         = CP_INDEX_SIZE + 1;       // count must reach CP_NUM
   localparam int LANE_IDX_W    = $clog2(RENAME_WIDTH);

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      RECOVER = 2'd1,
      DRAIN   = 2'd2
   } ctrl_state_t;

   // Distance from slot b forward to slot a around the ring. CP_NUM is a
   // power of two, so the natural wrap of the subtraction is the modulo.
   function automatic logic [CP_INDEX_SIZE-1:0] slot_dist(
      input logic [CP_INDEX_SIZE-1:0] a,
      input logic [CP_INDEX_SIZE-1:0] b
   );
      return a - b;
   endfunction

endpackage

// File: rtl/checkpoint_ctrl_first_br_finder.sv
// Priority encoder: lowest lane of the decode group holding a branch.
// Latency: combinational. Backpressure: none (pure function of its input).
// Ports: br_lanes (valid & is_br per lane) -> found flag, idx of lowest set lane.
module checkpoint_ctrl_first_br_finder
   import checkpoint_ctrl_pkg::*;
(
   input  logic [RENAME_WIDTH-1:0] br_lanes,
   output logic                    found,
   output logic [LANE_IDX_W-1:0]   idx
);

   // Scan from the top down so the lowest set lane is the last writer.
   always_comb begin
      found = 1'b0;
      idx   = '0;
      for (int i = RENAME_WIDTH - 1; i >= 0; i--) begin
         if (br_lanes[i]) begin
            found = 1'b1;
            idx   = LANE_IDX_W'(i);
         end
      end
   end

endmodule

// File: rtl/checkpoint_ctrl.sv
// Branch checkpoint scheduler: grants decode lanes, allocates/frees ring tags, runs mispredict recovery.
// Latency: grant/check combinational; recover registered (1 cycle after the mispredict), 3 cycles until grants resume.
// Backpressure: no grants unless rename_ready; a group is cut after its first branch, or before it when all slots are live.
// Ports:
//   clock, reset (sync, active-low)
//   dec_valid/dec_is_br/rename_ready -> lane_grant, br_tag, check, check_idx
//   resolve_valid/resolve_tag/resolve_mispredict -> recover, recover_idx
//   flush (ROB exception) ; cp_count, cp_full (occupancy)
module checkpoint_ctrl
   import checkpoint_ctrl_pkg::*;
(
   input  logic                      clock,
   input  logic                      reset,
   input  logic [RENAME_WIDTH-1:0]   dec_valid,
   input  logic [RENAME_WIDTH-1:0]   dec_is_br,
   input  logic                      rename_ready,
   output logic [RENAME_WIDTH-1:0]   lane_grant,
   output logic [CP_INDEX_SIZE-1:0]  br_tag,
   output logic                      check,
   output logic [CP_INDEX_SIZE-1:0]  check_idx,
   input  logic                      resolve_valid,
   input  logic [CP_INDEX_SIZE-1:0]  resolve_tag,
   input  logic                      resolve_mispredict,
   output logic                      recover,
   output logic [CP_INDEX_SIZE-1:0]  recover_idx,
   input  logic                      flush,
   output logic [CNT_W-1:0]          cp_count,
   output logic                      cp_full
);

   ctrl_state_t              state_q, state_d;
   logic [CP_INDEX_SIZE-1:0] head_q, head_d;
   logic [CP_INDEX_SIZE-1:0] tail_q, tail_d;
   logic [CNT_W-1:0]         count_q, count_d;
   logic [CP_NUM-1:0]        done_q, done_d;
   logic                     recover_d;
   logic [CP_INDEX_SIZE-1:0] recover_idx_d;

   logic                     br_found;
   logic [LANE_IDX_W-1:0]    br_idx;
   logic [CP_INDEX_SIZE-1:0] res_dist;
   logic                     res_live;
   logic                     mis_hit;
   logic                     ok_hit;
   logic                     grant_en;
   logic                     release_head;

   checkpoint_ctrl_first_br_finder u_first_br_finder (
      .br_lanes (dec_valid & dec_is_br),
      .found    (br_found),
      .idx      (br_idx)
   );

   assign cp_count = count_q;
   assign cp_full  = (count_q == CNT_W'(CP_NUM));

   // Liveness is measured from head; resolves for anything outside the
   // live window (including tags squashed by an earlier mispredict) are ignored.
   assign res_dist = slot_dist(resolve_tag, head_q);
   assign res_live = ({1'b0, res_dist} < count_q);
   assign mis_hit  = resolve_valid &  resolve_mispredict & res_live;
   assign ok_hit   = resolve_valid & ~resolve_mispredict & res_live;

   assign grant_en     = reset & ~flush & ~mis_hit & rename_ready & (state_q == RUN);
   assign release_head = (count_q != '0) & done_q[head_q];

   // Grant lanes up to and including the first branch; when every slot is
   // live, stop just short of it so it is re-presented once a slot frees.
   always_comb begin
      lane_grant = '0;
      check      = 1'b0;
      if (grant_en) begin
         if (!br_found) begin
            lane_grant = dec_valid;
         end else begin
            for (int i = 0; i < RENAME_WIDTH; i++) begin
               if ((LANE_IDX_W'(i) < br_idx) || ((LANE_IDX_W'(i) == br_idx) && !cp_full)) begin
                  lane_grant[i] = dec_valid[i];
               end
            end
            check = ~cp_full;
         end
      end
   end

   assign check_idx = check ? tail_q : '0;
   assign br_tag    = check ? tail_q : '0;

   always_comb begin
      head_d        = head_q;
      tail_d        = tail_q;
      count_d       = count_q;
      done_d        = done_q;
      recover_d     = 1'b0;
      recover_idx_d = '0;

      case (state_q)
         RECOVER: state_d = DRAIN;
         DRAIN:   state_d = RUN;
         default: state_d = RUN;
      endcase

      if (flush) begin
         head_d  = tail_q;
         count_d = '0;
         done_d  = '0;
         state_d = RUN;
      end else if (mis_hit) begin
         // Everything from the mispredicted tag onward is squashed; the
         // mispredicted slot itself becomes the next allocation. A pending
         // head release waits a cycle, its done bit is kept.
         tail_d  = resolve_tag;
         count_d = {1'b0, res_dist};
         for (int i = 0; i < CP_NUM; i++) begin
            if ({1'b0, slot_dist(CP_INDEX_SIZE'(i), head_q)} >= count_d) begin
               done_d[i] = 1'b0;
            end
         end
         state_d       = RECOVER;
         recover_d     = 1'b1;
         recover_idx_d = resolve_tag;
      end else begin
         if (ok_hit) begin
            done_d[resolve_tag] = 1'b1;
         end
         if (release_head) begin
            done_d[head_q] = 1'b0;
            head_d         = head_q + CP_INDEX_SIZE'(1);
         end
         if (check) begin
            tail_d = tail_q + CP_INDEX_SIZE'(1);
         end
         count_d = count_q + CNT_W'(check) - CNT_W'(release_head);
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q     <= RUN;
         head_q      <= '0;
         tail_q      <= '0;
         count_q     <= '0;
         done_q      <= '0;
         recover     <= 1'b0;
         recover_idx <= '0;
      end else begin
         state_q     <= state_d;
         head_q      <= head_d;
         tail_q      <= tail_d;
         count_q     <= count_d;
         done_q      <= done_d;
         recover     <= recover_d;
         recover_idx <= recover_idx_d;
      end
   end

endmodule

// File: tb/tb_checkpoint_ctrl.sv
// Directed self-checking bench for checkpoint_ctrl.
// Latency: n/a. Backpressure: n/a.
// Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
module tb_checkpoint_ctrl;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic [2:0] dec_valid = '0;
   logic [2:0] dec_is_br = '0;
   logic       rename_ready = 1'b1;
   logic [2:0] lane_grant;
   logic [1:0] br_tag;
   logic       check;
   logic [1:0] check_idx;
   logic       resolve_valid = 1'b0;
   logic [1:0] resolve_tag = '0;
   logic       resolve_mispredict = 1'b0;
   logic       recover;
   logic [1:0] recover_idx;
   logic       flush = 1'b0;
   logic [2:0] cp_count;
   logic       cp_full;

   int n_checks = 0;
   int n_fail   = 0;

   checkpoint_ctrl dut (
      .clock              (clock),
      .reset              (reset),
      .dec_valid          (dec_valid),
      .dec_is_br          (dec_is_br),
      .rename_ready       (rename_ready),
      .lane_grant         (lane_grant),
      .br_tag             (br_tag),
      .check              (check),
      .check_idx          (check_idx),
      .resolve_valid      (resolve_valid),
      .resolve_tag        (resolve_tag),
      .resolve_mispredict (resolve_mispredict),
      .recover            (recover),
      .recover_idx        (recover_idx),
      .flush              (flush),
      .cp_count           (cp_count),
      .cp_full            (cp_full)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      dec_valid          = '0;
      dec_is_br          = '0;
      rename_ready       = 1'b1;
      resolve_valid      = 1'b0;
      resolve_tag        = '0;
      resolve_mispredict = 1'b0;
      flush              = 1'b0;
   endtask

   task automatic do_reset();
      idle();
      reset = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      #1;
   endtask

   // Present one single-branch group per cycle, n times.
   task automatic alloc_n(input int n);
      for (int k = 0; k < n; k++) begin
         dec_valid = 3'b001;
         dec_is_br = 3'b001;
         tick();
      end
      idle();
      #1;
   endtask

   task automatic test_reset();
      idle();
      reset     = 1'b0;
      dec_valid = 3'b111;
      dec_is_br = 3'b010;
      tick();
      tick();
      n_checks++; if (lane_grant !== 3'b000) begin n_fail++; $display("FAIL reset_grant: got %b want 000", lane_grant); end
      n_checks++; if (check !== 1'b0) begin n_fail++; $display("FAIL reset_check: got %b want 0", check); end
      reset = 1'b1;
      idle();
      #1;
      n_checks++; if (cp_count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", cp_count); end
      n_checks++; if (recover !== 1'b0) begin n_fail++; $display("FAIL reset_recover: got %b want 0", recover); end
      n_checks++; if (cp_full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0", cp_full); end
   endtask

   task automatic test_grant_cut();
      do_reset();
      dec_valid = 3'b111;
      dec_is_br = 3'b010;
      #1;
      n_checks++; if (lane_grant !== 3'b011) begin n_fail++; $display("FAIL cut_grant: got %b want 011", lane_grant); end
      n_checks++; if (check !== 1'b1) begin n_fail++; $display("FAIL cut_check: got %b want 1", check); end
      n_checks++; if (check_idx !== 2'd0) begin n_fail++; $display("FAIL cut_idx: got %0d want 0", check_idx); end
      n_checks++; if (br_tag !== 2'd0) begin n_fail++; $display("FAIL cut_br_tag: got %0d want 0", br_tag); end
      tick();
      dec_valid = 3'b001;
      dec_is_br = 3'b000;
      #1;
      n_checks++; if (lane_grant !== 3'b001) begin n_fail++; $display("FAIL cut_rest_grant: got %b want 001", lane_grant); end
      n_checks++; if (cp_count !== 3'd1) begin n_fail++; $display("FAIL cut_count: got %0d want 1", cp_count); end
      n_checks++; if (check !== 1'b0) begin n_fail++; $display("FAIL cut_rest_check: got %b want 0", check); end
      rename_ready = 1'b0;
      #1;
      n_checks++; if (lane_grant !== 3'b000) begin n_fail++; $display("FAIL not_ready_grant: got %b want 000", lane_grant); end
      idle();
   endtask

   task automatic test_full();
      do_reset();
      alloc_n(4);
      n_checks++; if (cp_count !== 3'd4) begin n_fail++; $display("FAIL full_count: got %0d want 4", cp_count); end
      n_checks++; if (cp_full !== 1'b1) begin n_fail++; $display("FAIL full_flag: got %b want 1", cp_full); end
      dec_valid     = 3'b111;
      dec_is_br     = 3'b001;
      resolve_valid = 1'b1;
      resolve_tag   = 2'd0;
      #1;
      n_checks++; if (lane_grant !== 3'b000) begin n_fail++; $display("FAIL full_grant: got %b want 000", lane_grant); end
      n_checks++; if (check !== 1'b0) begin n_fail++; $display("FAIL full_check: got %b want 0", check); end
      tick();
      resolve_valid = 1'b0;
      #1;
      n_checks++; if (cp_count !== 3'd4) begin n_fail++; $display("FAIL full_done_count: got %0d want 4", cp_count); end
      tick();
      n_checks++; if (cp_count !== 3'd3) begin n_fail++; $display("FAIL full_release_count: got %0d want 3", cp_count); end
      n_checks++; if (lane_grant !== 3'b001) begin n_fail++; $display("FAIL full_wrap_grant: got %b want 001", lane_grant); end
      n_checks++; if (check_idx !== 2'd0) begin n_fail++; $display("FAIL full_wrap_idx: got %0d want 0", check_idx); end
      tick();
      idle();
      #1;
      n_checks++; if (cp_count !== 3'd4) begin n_fail++; $display("FAIL full_refill_count: got %0d want 4", cp_count); end
   endtask

   task automatic test_out_of_order();
      do_reset();
      alloc_n(3);
      resolve_valid = 1'b1;
      resolve_tag   = 2'd2;
      tick();
      idle();
      tick();
      n_checks++; if (cp_count !== 3'd3) begin n_fail++; $display("FAIL ooo_tag2_count: got %0d want 3", cp_count); end
      resolve_valid = 1'b1;
      resolve_tag   = 2'd0;
      tick();
      idle();
      tick();
      n_checks++; if (cp_count !== 3'd2) begin n_fail++; $display("FAIL ooo_tag0_count: got %0d want 2", cp_count); end
      tick();
      n_checks++; if (cp_count !== 3'd2) begin n_fail++; $display("FAIL ooo_hold_count: got %0d want 2", cp_count); end
      resolve_valid = 1'b1;
      resolve_tag   = 2'd1;
      tick();
      idle();
      tick();
      n_checks++; if (cp_count !== 3'd1) begin n_fail++; $display("FAIL ooo_tag1_count: got %0d want 1", cp_count); end
      tick();
      n_checks++; if (cp_count !== 3'd0) begin n_fail++; $display("FAIL ooo_empty_count: got %0d want 0", cp_count); end
      // Mispredict on a tag that is no longer live must be ignored.
      resolve_valid      = 1'b1;
      resolve_mispredict = 1'b1;
      resolve_tag        = 2'd1;
      dec_valid          = 3'b001;
      dec_is_br          = 3'b001;
      #1;
      n_checks++; if (lane_grant !== 3'b001) begin n_fail++; $display("FAIL stale_mis_grant: got %b want 001", lane_grant); end
      n_checks++; if (check_idx !== 2'd3) begin n_fail++; $display("FAIL stale_mis_idx: got %0d want 3", check_idx); end
      tick();
      idle();
      #1;
      n_checks++; if (recover !== 1'b0) begin n_fail++; $display("FAIL stale_mis_recover: got %b want 0", recover); end
      n_checks++; if (cp_count !== 3'd1) begin n_fail++; $display("FAIL stale_mis_count: got %0d want 1", cp_count); end
   endtask

   task automatic test_mispredict();
      do_reset();
      alloc_n(4);
      dec_valid          = 3'b111;
      dec_is_br          = 3'b000;
      resolve_valid      = 1'b1;
      resolve_mispredict = 1'b1;
      resolve_tag        = 2'd1;
      #1;
      n_checks++; if (lane_grant !== 3'b000) begin n_fail++; $display("FAIL mis_t0_grant: got %b want 000", lane_grant); end
      tick();
      resolve_valid      = 1'b0;
      resolve_mispredict = 1'b0;
      #1;
      n_checks++; if (recover !== 1'b1) begin n_fail++; $display("FAIL mis_t1_recover: got %b want 1", recover); end
      n_checks++; if (recover_idx !== 2'd1) begin n_fail++; $display("FAIL mis_t1_idx: got %0d want 1", recover_idx); end
      n_checks++; if (cp_count !== 3'd1) begin n_fail++; $display("FAIL mis_t1_count: got %0d want 1", cp_count); end
      n_checks++; if (lane_grant !== 3'b000) begin n_fail++; $display("FAIL mis_t1_grant: got %b want 000", lane_grant); end
      tick();
      n_checks++; if (recover !== 1'b0) begin n_fail++; $display("FAIL mis_t2_recover: got %b want 0", recover); end
      n_checks++; if (lane_grant !== 3'b000) begin n_fail++; $display("FAIL mis_t2_grant: got %b want 000", lane_grant); end
      tick();
      dec_valid = 3'b001;
      dec_is_br = 3'b001;
      #1;
      n_checks++; if (lane_grant !== 3'b001) begin n_fail++; $display("FAIL mis_t3_grant: got %b want 001", lane_grant); end
      n_checks++; if (check_idx !== 2'd1) begin n_fail++; $display("FAIL mis_t3_idx: got %0d want 1", check_idx); end
      tick();
      idle();
      #1;
      n_checks++; if (cp_count !== 3'd2) begin n_fail++; $display("FAIL mis_t4_count: got %0d want 2", cp_count); end
   endtask

   // Live tags 0,1: mispredict on 1, then on 0 while in RECOVER.
   task automatic test_recover_restart();
      resolve_valid      = 1'b1;
      resolve_mispredict = 1'b1;
      resolve_tag        = 2'd1;
      tick();
      resolve_tag        = 2'd0;
      #1;
      n_checks++; if (recover_idx !== 2'd1) begin n_fail++; $display("FAIL restart_first_idx: got %0d want 1", recover_idx); end
      tick();
      idle();
      dec_valid = 3'b001;
      #1;
      n_checks++; if (recover !== 1'b1) begin n_fail++; $display("FAIL restart_recover: got %b want 1", recover); end
      n_checks++; if (recover_idx !== 2'd0) begin n_fail++; $display("FAIL restart_idx: got %0d want 0", recover_idx); end
      n_checks++; if (cp_count !== 3'd0) begin n_fail++; $display("FAIL restart_count: got %0d want 0", cp_count); end
      tick();
      n_checks++; if (lane_grant !== 3'b000) begin n_fail++; $display("FAIL restart_drain_grant: got %b want 000", lane_grant); end
      tick();
      n_checks++; if (lane_grant !== 3'b001) begin n_fail++; $display("FAIL restart_run_grant: got %b want 001", lane_grant); end
      idle();
   endtask

   task automatic test_flush_vs_mispredict();
      do_reset();
      alloc_n(4);
      dec_valid          = 3'b111;
      dec_is_br          = 3'b000;
      flush              = 1'b1;
      resolve_valid      = 1'b1;
      resolve_mispredict = 1'b1;
      resolve_tag        = 2'd2;
      #1;
      n_checks++; if (lane_grant !== 3'b000) begin n_fail++; $display("FAIL flush_grant: got %b want 000", lane_grant); end
      tick();
      flush              = 1'b0;
      resolve_valid      = 1'b0;
      resolve_mispredict = 1'b0;
      dec_is_br          = 3'b100;
      #1;
      n_checks++; if (recover !== 1'b0) begin n_fail++; $display("FAIL flush_recover: got %b want 0", recover); end
      n_checks++; if (cp_count !== 3'd0) begin n_fail++; $display("FAIL flush_count: got %0d want 0", cp_count); end
      n_checks++; if (lane_grant !== 3'b111) begin n_fail++; $display("FAIL flush_run_grant: got %b want 111", lane_grant); end
      n_checks++; if (check_idx !== 2'd0) begin n_fail++; $display("FAIL flush_idx: got %0d want 0", check_idx); end
      idle();
   endtask

   initial begin
      test_reset();
      test_grant_cut();
      test_full();
      test_out_of_order();
      test_mispredict();
      test_recover_restart();
      test_flush_vs_mispredict();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
